div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU path. It sits upstream of the ALU: the ALU raises a request with its two operands and takes the quotient or remainder back once the unit signals completion. It is a radix-2 restoring divider, one quotient bit per cycle. Divide-by-zero and signed overflow follow RISC-V semantics and use a short bypass path.

---
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Latency 33 cycles (1 for divide-by-zero and signed overflow); start is ignored while busy.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   shifted, trial;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      done_d  = 1'b0;

      a_abs   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      b_abs   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
      // Partial remainder is always below the divisor, so its 33rd bit is
      // implicitly zero and only WIDTH bits are stored.
      shifted = {p_q, q_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               if (divisor == '0) begin
                  q_d     = '1;
                  p_d     = dividend;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = FINISH;
               end else if (is_signed && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1) begin
                  q_d     = {1'b1, {(WIDTH-1){1'b0}}};
                  p_d     = '0;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = FINISH;
               end else begin
                  q_d     = a_abs;
                  p_d     = '0;
                  dvs_d   = b_abs;
                  q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_d = is_signed & dividend[WIDTH-1];
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (!trial[WIDTH]) begin
               p_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               p_d = shifted[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            quot_d  = q_neg_q ? -q_q : q_q;
            rem_d   = r_neg_q ? -p_q : p_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared at done.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
      end else if (s) begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
         e.lat = 33;
      end else begin
         e.q = a / b; e.r = a % b; e.lat = 33;
      end
      return e;
   endfunction

   // Drives start for one edge and records the expected outcome.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      start     = 1'b1;
      sb.push_back(model(a, b, s));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Latency counts edges after the accepting edge; returns at the done negedge.
   task automatic wait_done(output int lat, output int busy_cyc, output bit busy_at_done, output bit to);
      lat = 0; busy_cyc = 0; busy_at_done = 1'b0; to = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i - 1;
            busy_at_done = busy;
            to = 1'b0;
            break;
         end
         if (busy) busy_cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++; if (quotient !== 32'd0) begin miscompares++; $display("FAIL reset_quot: got %h expected 0", quotient); end
      vectors++; if (remainder !== 32'd0) begin miscompares++; $display("FAIL reset_rem: got %h expected 0", remainder); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_ops(input string name, input logic [31:0] av[], input logic [31:0] bv[], input bit sv[]);
      int lat, bc; bit bad, to; exp_t e;
      for (int i = 0; i < av.size(); i++) begin
         issue(av[i], bv[i], sv[i]);
         wait_done(lat, bc, bad, to);
         e = sb.pop_front();
         vectors++; if (to) begin miscompares++; $display("FAIL %s[%0d] timeout: got no done expected done", name, i); end
         vectors++; if (lat !== e.lat) begin miscompares++; $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, e.lat); end
         vectors++; if (quotient !== e.q) begin miscompares++; $display("FAIL %s[%0d] quot: got %h expected %h", name, i, quotient, e.q); end
         vectors++; if (remainder !== e.r) begin miscompares++; $display("FAIL %s[%0d] rem: got %h expected %h", name, i, remainder, e.r); end
         vectors++; if (bc !== e.lat) begin miscompares++; $display("FAIL %s[%0d] busy_cycles: got %0d expected %0d", name, i, bc, e.lat); end
         vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL %s[%0d] busy_with_done: got 1 expected 0", name, i); end
      end
   endtask

   task automatic test_unsigned();
      test_ops("unsigned", '{32'd100, 32'h8000_0000, 32'd5}, '{32'd7, 32'hFFFF_FFFF, 32'd9}, '{1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_signed();
      test_ops("signed", '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9}, '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE}, '{1'b1, 1'b1, 1'b1});
   endtask

   task automatic test_special();
      test_ops("special", '{32'd5, 32'd5, 32'h8000_0000}, '{32'd0, 32'd0, 32'hFFFF_FFFF}, '{1'b0, 1'b1, 1'b1});
   endtask

   task automatic test_back_to_back();
      int lat, bc; bit bad, to; exp_t e;
      issue(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_done(lat, bc, bad, to);
      e = sb.pop_front();
      vectors++; if (to || lat !== 33) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 33", lat); end
      vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("FAIL b2b_first: got %h/%h expected %h/%h", quotient, remainder, e.q, e.r); end
      // Start raised during the done cycle must be taken with no bubble.
      issue(32'd10, 32'd3, 1'b0);
      vectors++; if (quotient !== 32'hFFFF_FFFF || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_hold: got quot %h busy %b expected ffffffff 1", quotient, busy); end
      wait_done(lat, bc, bad, to);
      e = sb.pop_front();
      vectors++; if (to || lat !== 33) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
      vectors++; if (quotient !== 32'd3 || remainder !== 32'd1) begin miscompares++; $display("FAIL b2b_second: got %h/%h expected 3/1", quotient, remainder); end
   endtask

   task automatic test_ignore_start();
      int lat, bc, pulses; bit bad, to; exp_t e;
      issue(32'd1000, 32'd3, 1'b0);
      repeat (4) @(posedge clk);
      #1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat, bc, bad, to);
      e = sb.pop_front();
      // Waiting began 5 edges after acceptance, so done lands 28 edges later.
      vectors++; if (to || lat !== 28) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 28", lat); end
      vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("FAIL ignore_result: got %h/%h expected %h/%h", quotient, remainder, e.q, e.r); end
      pulses = 0;
      repeat (40) begin @(negedge clk); if (done) pulses++; end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL ignore_extra_done: got %0d expected 0", pulses); end
   endtask

   task automatic test_reset_midop();
      int lat, bc, pulses; bit bad, to; exp_t e;
      issue(32'd12345678, 32'd9, 1'b0);
      void'(sb.pop_back());
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_flags: got busy %b done %b expected 0 0", busy, done); end
      vectors++; if (quotient !== 32'd0 || remainder !== 32'd0) begin miscompares++; $display("FAIL midrst_outputs: got %h/%h expected 0/0", quotient, remainder); end
      pulses = 0;
      repeat (40) begin @(negedge clk); if (done) pulses++; end
      vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst_done: got %0d expected 0", pulses); end
      issue(32'd12345678, 32'd9, 1'b0);
      wait_done(lat, bc, bad, to);
      e = sb.pop_front();
      vectors++; if (to || lat !== 33) begin miscompares++; $display("FAIL midrst_fresh_latency: got %0d expected 33", lat); end
      vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("FAIL midrst_fresh: got %h/%h expected %h/%h", quotient, remainder, e.q, e.r); end
   endtask

   task automatic test_random();
      int lat, bc; bit bad, to; exp_t e;
      logic [31:0] a, b; logic s;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : 32'($urandom);
         if (i % 7 == 3) b = 32'd0;
         if (i % 9 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         s = 1'($urandom_range(0, 1));
         issue(a, b, s);
         wait_done(lat, bc, bad, to);
         e = sb.pop_front();
         vectors++; if (to || lat !== e.lat) begin miscompares++; $display("FAIL rand[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
         vectors++; if (quotient !== e.q || remainder !== e.r) begin miscompares++; $display("FAIL rand[%0d] result %h/%h s=%b: got %h/%h expected %h/%h", i, a, b, s, quotient, remainder, e.q, e.r); end
         if (b != 32'd0) begin
            vectors++; if (quotient * b + remainder !== a) begin miscompares++; $display("FAIL rand[%0d] invariant: got %h expected %h", i, quotient * b + remainder, a); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_back_to_back();
      test_ignore_start();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
